// File: rtl/vector_dot_accum_pkg.sv
// Shared opcodes, readout sizing helpers and FSM state type for the
// vector dot-product accumulator.
package vdot_pkg;

  localparam logic [2:0] OP_LOAD_W   = 3'b000;
  localparam logic [2:0] OP_LOAD_A   = 3'b001;
  localparam logic [2:0] OP_READ_S   = 3'b010;
  localparam logic [2:0] OP_NOP      = 3'b011;
  localparam logic [2:0] OP_ACCUM    = 3'b100;
  localparam logic [2:0] OP_CLR_ACC  = 3'b101;
  localparam logic [2:0] OP_READ_ACC = 3'b110;
  localparam logic [2:0] OP_CLR_ALL  = 3'b111;

  localparam logic [5:0] BCAST_ADDR = 6'h3F;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int nbeats(input int acc_w, input int out_w);
    return (acc_w + out_w - 1) / out_w;
  endfunction

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

endpackage

// File: rtl/vector_dot_accum_mac_lane.sv
// One MAC lane: weight/activation registers and a signed or unsigned
// full-width product.
module mac_lane
  import vdot_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we_w,
  input  logic                  we_a,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  signed_mode,
  output logic [2*DATA_W-1:0]   prod
);

  logic [DATA_W-1:0]   w_q, w_d, a_q, a_d;
  logic [2*DATA_W-1:0] ext_w, ext_a;

  always_comb begin
    w_d = w_q;
    a_d = a_q;
    if (clr) begin
      w_d = '0;
      a_d = '0;
    end else begin
      if (we_w) w_d = data_in;
      if (we_a) a_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
      a_q <= '0;
    end else begin
      w_q <= w_d;
      a_q <= a_d;
    end
  end

  // The low 2*DATA_W bits of a product of sign-extended operands are the
  // signed product, so one multiplier serves both modes.
  always_comb begin
    ext_w = signed_mode ? {{DATA_W{w_q[DATA_W-1]}}, w_q} : {{DATA_W{1'b0}}, w_q};
    ext_a = signed_mode ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
    prod  = ext_w * ext_a;
  end

endmodule

// File: rtl/vector_dot_accum.sv
// Multi-lane dot product with persistent accumulator and a framed,
// MSB-first narrow readout of a result snapshot.
//
// state    | meaning
// ST_IDLE  | op_ready=1, ops are executed on acceptance
// ST_SHIFT | streaming snapshot beats, incoming ops are dropped
module vector_dot_accum
  import vdot_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [5:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              signed_mode,
  output logic              op_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy
);

  localparam int NB    = nbeats(ACC_W, OUT_W);
  localparam int CNT_W = clog2(NB) + 1;
  localparam int EXT   = ACC_W - 2 * DATA_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    snap_q, snap_d;
  logic [ACC_W-1:0]    dot;
  logic [2*DATA_W-1:0] prod [LANES];
  logic                lane_clr, load_w, load_a;
  logic [NB*OUT_W-1:0] snap_pad;
  logic [OUT_W-1:0]    beat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic hit;
    assign hit = (addr == BCAST_ADDR) || (addr == 6'(i));
    mac_lane #(.DATA_W(DATA_W)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .clr         (lane_clr),
      .we_w        (load_w && hit),
      .we_a        (load_a && hit),
      .data_in     (data_in),
      .signed_mode (signed_mode),
      .prod        (prod[i])
    );
  end

  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + (signed_mode ? {{EXT{prod[i][2*DATA_W-1]}}, prod[i]}
                               : {{EXT{1'b0}}, prod[i]});
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    snap_d   = snap_q;
    lane_clr = 1'b0;
    load_w   = 1'b0;
    load_a   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_LOAD_W:   load_w = 1'b1;
            OP_LOAD_A:   load_a = 1'b1;
            OP_READ_S: begin
              snap_d  = dot;
              cnt_d   = CNT_W'(NB - 1);
              state_d = ST_SHIFT;
            end
            OP_ACCUM:    acc_d = acc_q + dot;
            OP_CLR_ACC:  acc_d = '0;
            OP_READ_ACC: begin
              snap_d  = acc_q;
              cnt_d   = CNT_W'(NB - 1);
              state_d = ST_SHIFT;
            end
            OP_CLR_ALL: begin
              lane_clr = 1'b1;
              acc_d    = '0;
            end
            default: ;
          endcase
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      snap_q  <= snap_d;
    end
  end

  // Counter value selects the slice directly; top slice is zero-padded.
  always_comb begin
    snap_pad              = '0;
    snap_pad[ACC_W-1:0]   = snap_q;
    beat                  = '0;
    for (int b = 0; b < NB; b++) begin
      if (cnt_q == CNT_W'(b)) beat = snap_pad[b*OUT_W +: OUT_W];
    end
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign busy      = !op_ready;
  assign out_valid = (state_q == ST_SHIFT);
  assign out_last  = out_valid && (cnt_q == '0);
  assign out_data  = out_valid ? beat : '0;

endmodule

// File: tb/tb_vector_dot_accum.sv
// Self-checking bench for vector_dot_accum: directed vector table,
// hand-written stall/reset sequences and random ops against a model.
module tb_vector_dot_accum;
  import vdot_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [2:0] op;
  logic [5:0] addr;
  logic [7:0] data_in;
  logic       signed_mode;
  logic       op_ready, out_valid, out_last, busy;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mw [8];
  logic [7:0]  ma [8];
  logic [23:0] macc;

  vector_dot_accum dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .addr(addr),
    .data_in(data_in), .signed_mode(signed_mode), .op_ready(op_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  addr;
    logic [7:0]  data;
    logic        sm;
    logic [23:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model_dot(input logic sm);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      if (sm) s += int'(signed'(mw[i])) * int'(signed'(ma[i]));
      else    s += int'(mw[i]) * int'(ma[i]);
    end
    return s[23:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      mw[i] = 8'h00;
      ma[i] = 8'h00;
    end
    macc = 24'h0;
  endtask

  task automatic model_apply(input logic [2:0] o, input logic [5:0] ad,
                             input logic [7:0] d, input logic sm);
    case (o)
      OP_LOAD_W: for (int i = 0; i < 8; i++) if (ad == 6'h3F || ad == 6'(i)) mw[i] = d;
      OP_LOAD_A: for (int i = 0; i < 8; i++) if (ad == 6'h3F || ad == 6'(i)) ma[i] = d;
      OP_ACCUM:   macc = macc + model_dot(sm);
      OP_CLR_ACC: macc = 24'h0;
      OP_CLR_ALL: model_clear();
      default: ;
    endcase
  endtask

  // Called on the negedge of the first beat; leaves on the last beat's negedge.
  task automatic collect(output logic [23:0] v);
    logic ok;
    ok = 1'b1;
    v  = 24'h0;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) @(negedge clk);
      if (!(out_valid && !op_ready && busy && (out_last == (b == 2)))) ok = 1'b0;
      v = {v[15:0], out_data};
    end
    chk("frame_framing", ok, 1);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [5:0] ad, input logic [7:0] d,
                       input logic sm, output logic [23:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) chk("ready_timeout", op_ready, 1);
    op_valid = 1'b1; op = o; addr = ad; data_in = d; signed_mode = sm;
    model_apply(o, ad, d, sm);
    @(negedge clk);
    op_valid = 1'b0;
    v = 24'h0;
    if (o == OP_READ_S || o == OP_READ_ACC) collect(v);
  endtask

  vec_t vecs [];
  logic [23:0] got, expv;

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = OP_NOP; addr = '0; data_in = '0; signed_mode = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_op_ready", op_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;

    vecs = '{
      '{OP_LOAD_W,   6'h3F, 8'hFF, 1'b0, 24'h0},
      '{OP_LOAD_A,   6'h3F, 8'hFF, 1'b0, 24'h0},
      '{OP_READ_S,   6'h00, 8'h00, 1'b0, 24'h07F008},
      '{OP_CLR_ALL,  6'h00, 8'h00, 1'b0, 24'h0},
      '{OP_LOAD_W,   6'h00, 8'hFF, 1'b0, 24'h0},
      '{OP_LOAD_A,   6'h00, 8'h02, 1'b0, 24'h0},
      '{OP_READ_S,   6'h00, 8'h00, 1'b1, 24'hFFFFFE},
      '{OP_READ_S,   6'h00, 8'h00, 1'b0, 24'h0001FE},
      '{OP_CLR_ALL,  6'h00, 8'h00, 1'b0, 24'h0},
      '{OP_LOAD_W,   6'h00, 8'h03, 1'b0, 24'h0},
      '{OP_LOAD_A,   6'h00, 8'h04, 1'b0, 24'h0},
      '{OP_ACCUM,    6'h00, 8'h00, 1'b0, 24'h0},
      '{OP_ACCUM,    6'h00, 8'h00, 1'b1, 24'h0},
      '{OP_ACCUM,    6'h00, 8'h00, 1'b0, 24'h0},
      '{OP_READ_ACC, 6'h00, 8'h00, 1'b0, 24'h000024},
      '{OP_CLR_ACC,  6'h00, 8'h00, 1'b0, 24'h0},
      '{OP_READ_ACC, 6'h00, 8'h00, 1'b0, 24'h000000},
      '{OP_CLR_ALL,  6'h00, 8'h00, 1'b0, 24'h0},
      '{OP_LOAD_W,   6'h3F, 8'h02, 1'b0, 24'h0},
      '{OP_LOAD_A,   6'h3F, 8'h05, 1'b0, 24'h0},
      '{OP_LOAD_W,   6'h08, 8'h7F, 1'b0, 24'h0},
      '{OP_READ_S,   6'h00, 8'h00, 1'b0, 24'h000050}
    };
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].sm, got);
      if (vecs[i].op == OP_READ_S || vecs[i].op == OP_READ_ACC)
        chk($sformatf("vec%0d_value", i), got, vecs[i].exp);
    end

    // Stall: ops presented during a frame are dropped; the held load lands afterwards.
    begin
      int stalls;
      int n;
      @(negedge clk);
      op_valid = 1'b1; op = OP_READ_S; addr = '0; data_in = '0; signed_mode = 1'b0;
      @(negedge clk);
      stalls = 0;
      got = 24'h0;
      n = 0;
      while (!op_ready && n < 10) begin
        stalls++;
        got = {got[15:0], out_data};
        if (n == 0) begin op = OP_CLR_ALL; end
        else begin op = OP_LOAD_W; addr = 6'h00; data_in = 8'h09; end
        @(negedge clk);
        n++;
      end
      chk("stall_cycles", stalls, 3);
      chk("stall_frame_value", got, 24'h000050);
      chk("stall_ready_after", op_ready, 1);
      chk("stall_held_op", op, OP_LOAD_W);
      model_apply(OP_LOAD_W, 6'h00, 8'h09, 1'b0);
      @(negedge clk);
      op_valid = 1'b0;
      do_op(OP_READ_S, 6'h00, 8'h00, 1'b0, got);
      chk("stall_after_load", got, 24'h000073);
    end

    // Reset in the middle of a frame.
    do_op(OP_ACCUM, 6'h00, 8'h00, 1'b0, got);
    @(negedge clk);
    op_valid = 1'b1; op = OP_READ_ACC;
    @(negedge clk);
    op_valid = 1'b0;
    chk("rst_beat1_valid", out_valid, 1);
    @(negedge clk);
    chk("rst_beat2_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;
    model_clear();
    do_op(OP_READ_ACC, 6'h00, 8'h00, 1'b0, got);
    chk("rst_read_acc", got, 24'h0);
    do_op(OP_READ_S, 6'h00, 8'h00, 1'b1, got);
    chk("rst_read_s", got, 24'h0);

    // Random ops against the model.
    for (int k = 0; k < 300; k++) begin
      logic [2:0] ro;
      logic [5:0] ra;
      logic [7:0] rd;
      logic       rs;
      int         r;
      ro = 3'($urandom_range(0, 7));
      if (ro == OP_CLR_ALL && $urandom_range(0, 3) != 0) ro = OP_ACCUM;
      r  = $urandom_range(0, 9);
      ra = (r < 8) ? 6'(r) : (r == 8) ? 6'h3F : 6'($urandom_range(8, 62));
      rd = 8'($urandom);
      rs = 1'($urandom);
      expv = (ro == OP_READ_S) ? model_dot(rs) : macc;
      do_op(ro, ra, rd, rs, got);
      if (ro == OP_READ_S || ro == OP_READ_ACC)
        chk($sformatf("rand%0d_op%0d", k, ro), got, expv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vector_dot_accum.md
Name: vector_dot_accum

Overview:
Parametrised successor of the 8-lane in-SRAM dot-product engine. It holds LANES weight/activation register pairs and forms the sum of all lane products, either signed or unsigned. A persistent accumulator integrates successive dot products. Results are snapshotted and streamed out over a narrow bus with valid/last framing and an op_ready stall, so the host interface can sit directly behind the ui/uio pin decode.

Parameters:
LANES, 8, number of MAC lanes; 2..32.
DATA_W, 8, operand width.
ACC_W, 24, accumulator/result width; must be >= 2*DATA_W + clog2(LANES).
OUT_W, 8, readout beat width; NBEATS = ceil(ACC_W/OUT_W), which is 3 at defaults.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
op_valid  in  1  op/addr/data_in qualify this cycle
op  in  3  opcode
addr  in  6  lane address; 6'h3F = broadcast to all lanes
data_in  in  DATA_W  operand for loads
signed_mode  in  1  1 = two's-complement products and sum, 0 = unsigned
op_ready  out  1  op accepted when op_valid && op_ready
out_data  out  OUT_W  readout beat
out_valid  out  1  out_data valid
out_last  out  1  final beat of a frame
busy  out  1  readout in progress (equals !op_ready)

Behaviour:
- Reset (synchronous, rst=1 at edge): all w, a, acc and snapshot cleared to 0; state IDLE. Outputs: op_ready=1, out_valid=0, out_last=0, out_data=0, busy=0. Reset overrides everything, including an in-flight readout; out_valid is 0 from the next cycle.
- Opcodes:
  - LOAD_W=000: w[addr] <= data_in.
  - LOAD_A=001: a[addr] <= data_in.
  - READ_S=010: snapshot <= dot; start readout.
  - NOP=011: no effect.
  - ACCUM=100: acc <= acc + dot, wrapping mod 2^ACC_W.
  - CLR_ACC=101: acc <= 0.
  - READ_ACC=110: snapshot <= acc; start readout.
  - CLR_ALL=111: every w, a and acc <= 0.
- Load addressing:
  - addr < LANES writes that lane only.
  - addr == 6'h3F writes all lanes.
  - Any other addr is ignored; no state changes.
- dot (combinational):
  - Sum over lanes of w*a.
  - signed_mode=1: operands sign-extended and products summed signed, then sign-extended to ACC_W.
  - signed_mode=0: zero-extended.
  - signed_mode is sampled in the same cycle as the consuming op (READ_S/ACCUM).
- FSM IDLE -> SHIFT:
  - Entered on an accepted READ_S or READ_ACC. Beat counter loaded with NBEATS-1.
  - In SHIFT:
    - op_ready=0. Any op_valid is dropped with no effect; the host must hold the op.
    - out_valid=1 every cycle.
    - out_data = snapshot slice, MSB-first. The top slice is zero-padded when ACC_W is not a multiple of OUT_W.
    - out_last=1 on the beat whose counter is 0. Next state is IDLE and op_ready=1 in the following cycle.
  - Latency: op accepted at edge N; first beat valid in the cycle after edge N; last beat in the cycle after edge N+NBEATS-1. A new op can be accepted at edge N+NBEATS. No bubbles between beats.
- out_data=0 whenever out_valid=0.
- Loads and ACCUM in IDLE take effect at the accepting edge. A READ_S issued in the following cycle sees the new values.

Decomposition:
- Package vdot_pkg holds:
  - opcode localparams (OP_LOAD_W..OP_CLR_ALL);
  - BCAST_ADDR = 6'h3F;
  - clog2 and nbeats functions;
  - state enum {ST_IDLE, ST_SHIFT}.
- Sub-module mac_lane holds one lane: w/a registers with sync reset/clear, per-lane write enables, and a signed/unsigned 2*DATA_W product output. The top level instantiates LANES copies via generate and contains the reduction sum, accumulator, snapshot and readout FSM.

Test Plan:
1. Unsigned saturation: broadcast LOAD_W 0xFF, broadcast LOAD_A 0xFF, signed_mode=0, READ_S -> beats 0x07, 0xF0, 0x08 (520200); out_last on 3rd beat only.
2. Signed product: lane0 w=0xFF, a=0x02, other lanes 0, signed_mode=1, READ_S -> 0xFF, 0xFF, 0xFE (-2). Same state with signed_mode=0 -> 0x00, 0x01, 0xFE (510).
3. Accumulate: CLR_ALL; lane0 w=3, a=4; ACCUM x3; READ_ACC -> 0x00, 0x00, 0x24 (36). Then CLR_ACC and READ_ACC -> 0x00, 0x00, 0x00.
4. Addressing: after CLR_ALL, broadcast LOAD_W 2, broadcast LOAD_A 5, LOAD_W addr=8 data=0x7F (ignored), READ_S -> 0x00, 0x00, 0x50 (80).
5. Stall: READ_S, then hold op_valid with LOAD_W lane0=9 during beats -> op_ready=0 for 3 cycles, w0 unchanged. LOAD_W is accepted the cycle after out_last; the next READ_S reflects w0=9.
6. Reset mid-frame: assert rst during beat 2 of a readout -> out_valid=0, out_data=0, op_ready=1 next cycle. Subsequent READ_ACC -> 0x00, 0x00, 0x00.
